// File: rtl/grostl_compress_serial_mp.sv
// Serial Groestl compression H' = P(Hc^m) ^ Q(m) ^ Hc. One two-stage masked round
// datapath is shared: Q runs first on S, S and A swap, then P runs.
module grostl_compress_serial_mp #(
    parameter int COLS   = 8,
    parameter int ROUNDS = 10,
    parameter bit MASKED = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 first,
    input  logic [64*COLS-1:0]   m_in,
    input  logic [64*COLS-1:0]   h_in,
    input  logic [64*COLS-1:0]   imask,
    input  logic [64*COLS-1:0]   omask,
    output logic                 ready,
    output logic                 done,
    output logic [64*COLS-1:0]   dout,
    output logic [2:0]           o_dbg_state
);
    localparam int W   = 64 * COLS;
    localparam int RCW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    typedef enum logic [2:0] {IDLE, Q1, Q2, SWAP, P1, P2, FINAL} state_t;

    // Byte (row, col) of a state vector; columns are filled top byte first.
    function automatic int bpos(input int row, input int col);
        return W - 1 - 8 * (8 * col + row);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // AES S-box: inverse as x^254, then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq, b;
        sq = gf_mul(x, x);
        b  = sq;
        for (int i = 0; i < 6; i++) begin
            sq = gf_mul(sq, sq);
            b  = gf_mul(b, sq);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic int shift_of(input int row, input logic q);
        if (!q) return (row == 7) ? ((COLS == 16) ? 11 : 7) : row;
        if (row == 3) return (COLS == 16) ? 11 : 7;
        return (row < 4) ? 2 * row + 1 : 2 * (row - 4);
    endfunction

    function automatic logic [7:0] mix_coef(input int d);
        case (d)
            0, 1:    return 8'h02;
            2:       return 8'h03;
            3:       return 8'h04;
            4:       return 8'h05;
            5:       return 8'h03;
            6:       return 8'h05;
            default: return 8'h07;
        endcase
    endfunction

    function automatic logic [W-1:0] add_rc(input logic [W-1:0] s, input logic [RCW-1:0] r, input logic q);
        logic [W-1:0] o;
        o = s;
        for (int c = 0; c < COLS; c++) begin
            if (q) begin
                for (int row = 0; row < 8; row++) o[bpos(row, c) -: 8] = ~s[bpos(row, c) -: 8];
                o[bpos(7, c) -: 8] = o[bpos(7, c) -: 8] ^ 8'(16 * c) ^ 8'(r);
            end else begin
                o[bpos(0, c) -: 8] = s[bpos(0, c) -: 8] ^ 8'(16 * c) ^ 8'(r);
            end
        end
        return o;
    endfunction

    function automatic logic [W-1:0] sub_masked(input logic [W-1:0] x, input logic [W-1:0] im,
                                                input logic [W-1:0] om);
        logic [W-1:0] o;
        for (int k = 0; k < W / 8; k++) o[8*k +: 8] = sbox(x[8*k +: 8] ^ im[8*k +: 8]) ^ om[8*k +: 8];
        return o;
    endfunction

    function automatic logic [W-1:0] shift_bytes(input logic [W-1:0] s, input logic q);
        logic [W-1:0] o;
        for (int row = 0; row < 8; row++)
            for (int c = 0; c < COLS; c++)
                o[bpos(row, c) -: 8] = s[bpos(row, (c + shift_of(row, q)) % COLS) -: 8];
        return o;
    endfunction

    function automatic logic [W-1:0] mix_bytes(input logic [W-1:0] s);
        logic [W-1:0] o;
        logic [7:0]   acc;
        for (int c = 0; c < COLS; c++)
            for (int i = 0; i < 8; i++) begin
                acc = 8'h00;
                for (int k = 0; k < 8; k++) acc = acc ^ gf_mul(mix_coef((k - i + 8) % 8), s[bpos(k, c) -: 8]);
                o[bpos(i, c) -: 8] = acc;
            end
        return o;
    endfunction

    state_t           r_state;
    logic [W-1:0]     r_s, r_a, r_pr, r_h, r_im, r_om;
    logic [RCW-1:0]   r_rc;
    logic             r_ready, r_done;

    logic             w_is_q, w_last;
    logic [W-1:0]     w_hc, w_im, w_om, w_sub, w_mix;

    assign w_is_q = (r_state == Q1) || (r_state == Q2);
    assign w_last = (r_rc == RCW'(ROUNDS - 1));
    assign w_hc   = first ? h_in : r_h;
    assign w_im   = MASKED ? imask : '0;
    assign w_om   = MASKED ? omask : '0;
    assign w_sub  = sub_masked(add_rc(r_s, r_rc, w_is_q), r_im, r_om);
    // Removing the linear image of OM and adding IM keeps S masked by IM across rounds.
    assign w_mix  = mix_bytes(shift_bytes(r_pr, w_is_q)) ^ mix_bytes(shift_bytes(r_om, w_is_q)) ^ r_im;

    // start/ready: a compression is accepted on a rising edge with start && ready; start at any
    // other time is dropped, never queued. done pulses one cycle when dout carries the new H.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_a     <= '0;
            r_pr    <= '0;
            r_h     <= '0;
            r_im    <= '0;
            r_om    <= '0;
            r_rc    <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_s     <= m_in ^ w_im;
                    r_a     <= w_hc ^ m_in ^ w_im;
                    r_h     <= w_hc;
                    r_im    <= w_im;
                    r_om    <= w_om;
                    r_rc    <= '0;
                    r_ready <= 1'b0;
                    r_state <= Q1;
                end
                Q1, P1: begin
                    r_pr    <= w_sub;
                    r_state <= (r_state == Q1) ? Q2 : P2;
                end
                Q2, P2: begin
                    r_s <= w_mix;
                    if (w_last) begin
                        r_rc    <= '0;
                        r_state <= (r_state == Q2) ? SWAP : FINAL;
                    end else begin
                        r_rc    <= r_rc + 1'b1;
                        r_state <= (r_state == Q2) ? Q1 : P1;
                    end
                end
                SWAP: begin
                    r_s     <= r_a;
                    r_a     <= r_s;
                    r_state <= P1;
                end
                FINAL: begin
                    r_h     <= r_s ^ r_a ^ r_h;
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready       = r_ready;
    assign done        = r_done;
    assign dout        = r_h;
    assign o_dbg_state = r_state;
endmodule

// File: doc/grostl_compress_serial_mp.md
GROSTL_COMPRESS_SERIAL_MP -- requirements
Module: grostl_compress_serial_mp

Interface
REQ-001 Parameter COLS, default 8, state columns (8 = Grostl-224/256 P512/Q512; 16 = Grostl-384/512 P1024/Q1024); W = 64*COLS.
REQ-002 Parameter ROUNDS, default 10, rounds per permutation (10 for COLS=8, 14 for COLS=16).
REQ-003 Parameter MASKED, default 1; 0 forces internal imask/omask to zero (unmasked build).
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request one compression; accepted only when ready=1.
REQ-007 first  input  1  1: chaining input is h_in (IV); 0: chaining input is internal H.
REQ-008 m_in  input  W  message block, unmasked.
REQ-009 h_in  input  W  initial chaining value.
REQ-010 imask, omask  input  W  S-box input/output masks; sampled on start acceptance.
REQ-011 ready  output  1  idle, start will be accepted.
REQ-012 done  output  1  one-cycle pulse, H updated.
REQ-013 dout  output  W  current H register (unmasked).

Function
REQ-014 Computes H' = P(Hc ^ m) ^ Q(m) ^ Hc, Hc = first ? h_in : H; Grostl round constants and ShiftBytes offsets selected by COLS and by P/Q.
REQ-015 Registers: S (working state, W), A (alternate state, W), PR (pipeline, W), H (W), IM/OM (masks, W), round counter rc (0..ROUNDS-1), FSM.
REQ-016 FSM states: IDLE, Q1, Q2, SWAP, P1, P2, FINAL; ready=1 only in IDLE.
REQ-017 IDLE & start: S <= m_in^imask; A <= Hc^m_in^imask; H <= Hc; IM <= imask; OM <= omask; rc <= 0; -> Q1.
REQ-018 IDLE & !start: all registers hold.
REQ-019 Q1/P1 (stage 1): PR <= SubBytes_masked(AddRoundConstant(S, rc), IM, OM); -> Q2/P2.
REQ-020 Q2/P2 (stage 2): S <= MixBytes(ShiftBytes(PR)) ^ MixBytes(ShiftBytes(OM)) ^ IM, so S stays masked by IM; rc==ROUNDS-1 ? (rc<=0, -> SWAP / FINAL) : (rc<=rc+1, -> Q1 / P1).
REQ-021 SWAP: S <= A; A <= S; -> P1.
REQ-022 FINAL: H <= S ^ A ^ H (mask IM cancels); done <= 1 for exactly one cycle; -> IDLE.
REQ-023 Latency: done high in the cycle following edge 4*ROUNDS+2 after the accepting edge (42 cycles for ROUNDS=10, 58 for ROUNDS=14); ready high again in the same cycle.
REQ-024 start while busy is ignored, no queuing; start in the done cycle is accepted (back-to-back, one compression every 4*ROUNDS+3 cycles).
REQ-025 imask/omask changes after acceptance have no effect on the result; m_in/h_in only sampled at acceptance.
REQ-026 No unmasked intermediate of S, A, or PR is ever stored in a register; only H and dout are unmasked.
REQ-027 Result is identical for any mask values, and identical to MASKED=0.
REQ-028 first=0 on the first compression after reset chains from H=0.

Reset
REQ-029 rst=1 asynchronously forces FSM=IDLE and S, A, PR, H, IM, OM, rc to 0, done=0, ready=1, dout=0.
REQ-030 rst mid-compression aborts it; H is zero, not partially updated, and the next start begins a fresh compression.

Verification
REQ-031 COLS=8, first=1, h_in=IV256 (0x...0100), m_in=final padded empty block, masks 0 -> done at cycle 42, dout equals the golden-model P512/Q512 compression output.
REQ-032 Same stimulus with random nonzero imask/omask, and with MASKED=0 -> dout bit-identical to REQ-031 result.
REQ-033 COLS=16, ROUNDS=14, h_in=IV512 (0x...0200), random m_in/masks -> done at cycle 58, dout matches golden model.
REQ-034 Two blocks: start in the done cycle with first=0 -> second done 43 cycles later, dout = f(f(IV,m0),m1).
REQ-035 start pulsed at cycles 5 and 20 of a busy compression, masks toggled mid-run -> ignored, single done, result unchanged.
REQ-036 rst asserted at cycle 17 of a compression -> immediate ready=1, done=0, dout=0; a subsequent start yields the correct result.
